// File: rtl/fetch_stage.sv
// fetch_stage: PC register and IF/ID pipeline register for the P7 pipelined MIPS core.
//
// Ports:
//   clk, reset          clock (rising edge) and asynchronous active-low reset
//   newPc               next PC from the next-PC logic, loaded when a fetch retires
//   stall_D             hazard unit hold request for PC and IF/ID
//   Req                 CP0 exception/interrupt flush (highest priority)
//   Eret_D              eret in D: the instruction fetched behind it is discarded
//   br_D                instruction in D is a branch/jump; next loaded word is a delay slot
//   imem_req/addr/rdata/ack  variable-latency request/acknowledge instruction memory port
//   pc_F                current fetch PC (WPC of the next-PC logic)
//   instr_D, pc_D, exc_D, bd_D  IF/ID register contents
//   fetch_busy          no instruction ready this cycle
module fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO   = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI   = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] newPc,
  input  logic        stall_D,
  input  logic        Req,
  input  logic        Eret_D,
  input  logic        br_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc_F,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [4:0]  exc_D,
  output logic        bd_D,
  output logic        fetch_busy
);

  localparam logic [4:0] ExcNone = 5'd0;
  localparam logic [4:0] ExcAdel = 5'd4;

  typedef enum logic [1:0] {StReq, StWait, StHold, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [4:0]  exc_q, exc_d;
  logic        bd_q, bd_d;
  logic [31:0] buf_word_q, buf_word_d;
  logic [4:0]  buf_exc_q, buf_exc_d;
  // Address of the abandoned request that DRAIN must keep presenting until acked.
  logic [31:0] drain_addr_q, drain_addr_d;

  logic        pc_illegal;
  logic        complete;
  logic [31:0] word;
  logic [4:0]  word_exc;

  assign pc_illegal = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);

  // State and pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StReq;
      pc_q         <= PC_RESET;
      instr_q      <= 32'd0;
      pcd_q        <= 32'd0;
      exc_q        <= ExcNone;
      bd_q         <= 1'b0;
      buf_word_q   <= 32'd0;
      buf_exc_q    <= ExcNone;
      drain_addr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pcd_q        <= pcd_d;
      exc_q        <= exc_d;
      bd_q         <= bd_d;
      buf_word_q   <= buf_word_d;
      buf_exc_q    <= buf_exc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    complete = 1'b0;
    word     = 32'd0;
    word_exc = ExcNone;
    unique case (state_q)
      StReq: begin
        // An illegal PC never reaches memory: it retires at once as word 0 with AdEL.
        complete = pc_illegal || imem_ack;
        word     = pc_illegal ? 32'd0 : imem_rdata;
        word_exc = pc_illegal ? ExcAdel : ExcNone;
      end
      StWait: begin
        complete = imem_ack;
        word     = imem_rdata;
      end
      StHold: begin
        complete = 1'b1;
        word     = buf_word_q;
        word_exc = buf_exc_q;
      end
      StDrain: complete = 1'b0;
      default: complete = 1'b0;
    endcase

    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pcd_d        = pcd_q;
    exc_d        = exc_q;
    bd_d         = bd_q;
    buf_word_d   = buf_word_q;
    buf_exc_d    = buf_exc_q;
    drain_addr_d = drain_addr_q;

    if (Req) begin
      pc_d    = EXC_ENTRY;
      instr_d = 32'd0;
      pcd_d   = EXC_ENTRY;
      exc_d   = ExcNone;
      bd_d    = 1'b0;
      // An outstanding request must still be acked before fetching from EXC_ENTRY.
      if ((state_q == StWait || state_q == StDrain) && !imem_ack) begin
        state_d = StDrain;
        if (state_q == StWait) drain_addr_d = pc_q;
      end else begin
        state_d = StReq;
      end
    end else if (state_q == StDrain) begin
      if (imem_ack) state_d = StReq;
      if (!stall_D) begin
        instr_d = 32'd0;
        pcd_d   = pc_q;
        exc_d   = ExcNone;
        bd_d    = 1'b0;
      end
    end else if (complete && !stall_D) begin
      state_d = StReq;
      pc_d    = newPc;
      pcd_d   = pc_q;
      if (Eret_D) begin
        instr_d = 32'd0;
        exc_d   = ExcNone;
        bd_d    = 1'b0;
      end else begin
        instr_d = word;
        exc_d   = word_exc;
        bd_d    = br_D;
      end
    end else if (complete) begin
      state_d    = StHold;
      buf_word_d = word;
      buf_exc_d  = word_exc;
    end else begin
      // Only REQ/WAIT without ack reach here; the request stays open in WAIT.
      state_d = StWait;
      if (!stall_D) begin
        instr_d = 32'd0;
        pcd_d   = pc_q;
        exc_d   = ExcNone;
        bd_d    = 1'b0;
      end
    end
  end

  // Outputs.
  always_comb begin
    imem_req   = 1'b0;
    fetch_busy = 1'b0;
    imem_addr  = (state_q == StDrain) ? drain_addr_q : pc_q;
    unique case (state_q)
      StReq: begin
        imem_req   = !pc_illegal;
        fetch_busy = !pc_illegal && !imem_ack;
      end
      StWait: begin
        imem_req   = 1'b1;
        fetch_busy = 1'b1;
      end
      StHold: begin
        imem_req   = 1'b0;
        fetch_busy = 1'b0;
      end
      StDrain: begin
        imem_req   = 1'b1;
        fetch_busy = 1'b1;
      end
      default: begin
        imem_req   = 1'b0;
        fetch_busy = 1'b0;
      end
    endcase
    // No request may leave the block while reset is held.
    imem_req = imem_req && reset;
  end

  assign pc_F    = pc_q;
  assign instr_D = instr_q;
  assign pc_D    = pcd_q;
  assign exc_D   = exc_q;
  assign bd_D    = bd_q;

endmodule
